// File: rtl/f1_reaction_timer_if.sv
// Light-bar bus between the F1 start-light sequencer (master) and its readers (slave).
interface f1_reaction_timer_if;
    logic [7:0] data;

    modport master (output data);
    modport slave  (input  data);
endinterface

// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: watches the start-light bar, times the driver from lights out to the
// trigger press in tick units, and flags jump starts and timeouts.
// Optional feature: define F1_BEST_TIME_EN to keep the best (minimum) valid reaction time.
module f1_reaction_timer #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    f1_reaction_timer_if.slave    light_bar,
    input  logic                  tick_i,
    input  logic                  trigger_i,
    output logic [CNT_WIDTH-1:0]  react_time_o,
    output logic                  result_valid_o,
    output logic                  jump_start_o,
    output logic                  timeout_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  best_time_o
);

    typedef enum logic [2:0] {StIdle, StArmed, StFull, StTiming, StDone, StJump} state_e;

    localparam logic [CNT_WIDTH-1:0] TimeoutCnt  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] counter_q, counter_d;
    logic [CNT_WIDTH-1:0] react_time_q, react_time_d;
    logic                 result_valid_q, result_valid_d;
    logic                 jump_start_q, jump_start_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 trigger_q;
    logic                 press;
    logic [7:0]           bar;

    assign bar   = light_bar.data;
    // Only the rising edge counts, so a held button is a single press.
    assign press = trigger_i & ~trigger_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bar == 8'h01) state_d = StArmed;
            end
            StArmed: begin
                if (press)              state_d = StJump;
                else if (bar == 8'hFF)  state_d = StFull;
                else if (bar == 8'h00)  state_d = StIdle;
            end
            StFull: begin
                if (press)              state_d = StJump;
                else if (bar == 8'h00)  state_d = StTiming;
                else if (bar != 8'hFF)  state_d = StIdle;
            end
            StTiming: begin
                if (press)                                  state_d = StDone;
                else if (tick_i && counter_q == TimeoutLast) state_d = StDone;
            end
            StDone, StJump: begin
                // Holding the button parks here, which blocks re-arming.
                if (!trigger_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        counter_d      = counter_q;
        react_time_d   = react_time_q;
        result_valid_d = 1'b0;
        jump_start_d   = jump_start_q;
        timeout_d      = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (bar == 8'h01) begin
                    jump_start_d = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            StArmed: begin
                if (press) jump_start_d = 1'b1;
            end
            StFull: begin
                if (press)             jump_start_d = 1'b1;
                else if (bar == 8'h00) counter_d    = '0;
            end
            StTiming: begin
                // A tick coinciding with the press is not added to the result.
                if (press) begin
                    react_time_d   = counter_q;
                    result_valid_d = 1'b1;
                end else if (tick_i) begin
                    if (counter_q == TimeoutLast) begin
                        counter_d      = TimeoutCnt;
                        react_time_d   = TimeoutCnt;
                        timeout_d      = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        counter_d = counter_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d == StArmed) || (state_d == StFull) || (state_d == StTiming);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q      <= '0;
            react_time_q   <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            trigger_q      <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            react_time_q   <= react_time_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            trigger_q      <= trigger_i;
        end
    end

    assign react_time_o   = react_time_q;
    assign result_valid_o = result_valid_q;
    assign jump_start_o   = jump_start_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = busy_q;

`ifdef F1_BEST_TIME_EN
    logic [CNT_WIDTH-1:0] best_time_q, best_time_d;

    // Best time: only a real press (never a timeout) that strictly beats the record
    always_comb begin
        best_time_d = best_time_q;
        if (state_q == StTiming && press && counter_q < best_time_q) begin
            best_time_d = counter_q;
        end
    end

    // Best-time register, lands in the same cycle as result_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            best_time_q <= '1;
        end else begin
            best_time_q <= best_time_d;
        end
    end

    assign best_time_o = best_time_q;
`else
    assign best_time_o = '1;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer with a result scoreboard.
module tb_f1_reaction_timer;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 1000;

`ifdef F1_BEST_TIME_EN
    localparam bit BestEn = 1'b1;
`else
    localparam bit BestEn = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] rt;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          trigger;
    logic [CW-1:0] react_time;
    logic          result_valid;
    logic          jump_start;
    logic          timeout;
    logic          busy;
    logic [CW-1:0] best_time;

    int   checks    = 0;
    int   errors    = 0;
    int   n_results = 0;
    int   r0;
    exp_t sb[$];
    exp_t mon_e;

    f1_reaction_timer_if bar_if ();

    f1_reaction_timer #(
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .light_bar      (bar_if),
        .tick_i         (tick),
        .trigger_i      (trigger),
        .react_time_o   (react_time),
        .result_valid_o (result_valid),
        .jump_start_o   (jump_start),
        .timeout_o      (timeout),
        .busy_o         (busy),
        .best_time_o    (best_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] bexp(input logic [CW-1:0] v);
        return BestEn ? v : {CW{1'b1}};
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_bar();
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            bar_if.data = v;
            cyc(1);
            v = {v[6:0], 1'b1};
        end
        bar_if.data = 8'h00;
        cyc(1);
    endtask

    task automatic timed_press(input int n, input logic [CW-1:0] best_exp);
        fill_bar();
        chk("timing_busy", busy, 1);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
        trigger = 1'b1;
        sb.push_back('{rt: CW'(n), to: 1'b0});
        r0 = n_results;
        cyc(1);
        chk("press_rv", result_valid, 1);
        chk("press_react", react_time, n);
        chk("press_timeout", timeout, 0);
        chk("press_jump", jump_start, 0);
        chk("press_busy", busy, 0);
        chk("press_best", best_time, best_exp);
        trigger = 1'b0;
        cyc(1);
        chk("press_rv_one_cycle", result_valid, 0);
        chk("press_result_count", n_results, r0 + 1);
    endtask

    task automatic timeout_run(input logic [CW-1:0] best_exp);
        fill_bar();
        tick = 1'b1;
        cyc(TO - 1);
        chk("to_pre_rv", result_valid, 0);
        chk("to_pre_busy", busy, 1);
        sb.push_back('{rt: CW'(TO), to: 1'b1});
        cyc(1);
        chk("to_rv", result_valid, 1);
        chk("to_react", react_time, TO);
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_best", best_time, best_exp);
        tick = 1'b0;
        cyc(1);
        chk("to_rv_one_cycle", result_valid, 0);
    endtask

    // Scoreboard: every result_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            n_results++;
            if (sb.size() == 0) begin
                chk("spurious_result_valid", {31'b0, result_valid}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_react_time", react_time, mon_e.rt);
                chk("sb_timeout", timeout, mon_e.to);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        trigger = 1'b0;
        bar_if.data = 8'h00;
        cyc(2);
        chk("rst_react", react_time, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_jump", jump_start, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_best", best_time, 16'hFFFF);
        rst = 1'b0;
        cyc(1);

        // Normal run: 37 ticks then press
        timed_press(37, bexp(16'd37));

        // Jump start at pattern 07, button held through the rest of the sequence
        bar_if.data = 8'h01; cyc(1);
        chk("arm_busy", busy, 1);
        bar_if.data = 8'h03; cyc(1);
        bar_if.data = 8'h07;
        trigger = 1'b1;
        r0 = n_results;
        cyc(1);
        chk("jump_flag", jump_start, 1);
        chk("jump_rv", result_valid, 0);
        chk("jump_react_kept", react_time, 37);
        chk("jump_busy", busy, 0);
        bar_if.data = 8'hFF; cyc(1);
        bar_if.data = 8'h00; cyc(1);
        bar_if.data = 8'h01; cyc(2);
        chk("jump_held_no_arm", busy, 0);
        chk("jump_held_flag", jump_start, 1);
        bar_if.data = 8'h00;
        trigger = 1'b0;
        cyc(2);
        chk("jump_release_flag", jump_start, 1);
        chk("jump_no_result", n_results, r0);
        bar_if.data = 8'h01; cyc(1);
        chk("rearm_clears_jump", jump_start, 0);
        chk("rearm_busy", busy, 1);
        bar_if.data = 8'h00; cyc(1);
        chk("abort_idle", busy, 0);

        // Timeout, then a late press must be ignored
        timeout_run(bexp(16'd37));
        r0 = n_results;
        trigger = 1'b1; cyc(1);
        trigger = 1'b0; cyc(2);
        chk("late_press_no_result", n_results, r0);
        chk("late_press_no_jump", jump_start, 0);
        chk("late_press_timeout_kept", timeout, 1);

        // Press coinciding with a tick at counter 5; hold through the next 01
        fill_bar();
        chk("arm_clears_timeout", timeout, 0);
        tick = 1'b1;
        cyc(5);
        trigger = 1'b1;
        sb.push_back('{rt: CW'(5), to: 1'b0});
        cyc(1);
        tick = 1'b0;
        chk("tick_press_react", react_time, 5);
        chk("tick_press_best", best_time, bexp(16'd5));
        bar_if.data = 8'h01; cyc(2);
        chk("held_done_no_arm", busy, 0);
        bar_if.data = 8'h00;
        trigger = 1'b0;
        cyc(2);

        // Reset mid-TIMING at counter 200
        fill_bar();
        tick = 1'b1;
        cyc(200);
        tick = 1'b0;
        chk("mid_timing_busy", busy, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_react", react_time, 0);
        chk("midrst_rv", result_valid, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_best", best_time, 16'hFFFF);
        bar_if.data = 8'hFF; cyc(2);
        chk("ff_without_arm", busy, 0);
        bar_if.data = 8'h00; cyc(1);
        chk("ff_then_00_idle", busy, 0);

        // Best-time sequence
        timed_press(250, bexp(16'd250));
        timed_press(180, bexp(16'd180));
        timed_press(180, bexp(16'd180));
        timeout_run(bexp(16'd180));
        cyc(2);
        chk("final_best", best_time, bexp(16'd180));

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
